// File: rtl/dtcm_lsu_port_if.sv
// dtcm_lsu_port_if: CPU request/response bus plus DTCM RAM port; slave = LSU, master = CPU/RAM side
interface dtcm_lsu_port_if #(parameter int ADDR_WIDTH = 9);
  logic                  req_valid;
  logic                  req_ready;
  logic [31:0]           req_addr;
  logic                  req_we;
  logic [1:0]            req_size;
  logic                  req_unsigned;
  logic [31:0]           req_wdata;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [31:0]           rsp_rdata;
  logic                  rsp_err;
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic [31:0]           ram_wr_data;
  logic                  ram_wr_en;
  logic [3:0]            ram_wr_byte_en;
  logic [31:0]           ram_rd_data;
  modport slave (
    input  req_valid, req_addr, req_we, req_size, req_unsigned, req_wdata, rsp_ready, ram_rd_data,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, ram_addr, ram_wr_data, ram_wr_en, ram_wr_byte_en
  );
  modport master (
    output req_valid, req_addr, req_we, req_size, req_unsigned, req_wdata, rsp_ready, ram_rd_data,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, ram_addr, ram_wr_data, ram_wr_en, ram_wr_byte_en
  );
endinterface

// File: rtl/dtcm_lsu_port.sv
// dtcm_lsu_port: load/store port driving a 1-cycle-latency DTCM from a valid/ready CPU bus (ports: clk, rst, bus.slave)
module dtcm_lsu_port #(
  parameter int          ADDR_WIDTH = 9,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
  input logic clk,
  input logic rst,
  dtcm_lsu_port_if.slave bus
);
  localparam logic [32:0] WIN = 33'd4 << ADDR_WIDTH;
  logic                  acc, err, ext, pop;
  logic [1:0]            off;
  logic [31:0]           offs, sh, fmt_rdata;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  p_valid, p_we, p_uns, p_err;
  logic [1:0]            p_size, p_off;
  logic [31:0]           fifo_rdata [3];
  logic                  fifo_err [3];
  logic [1:0]            wptr, rptr, count;
  assign off  = bus.req_addr[1:0];
  assign offs = bus.req_addr - BASE_ADDR;
  assign acc  = bus.req_valid & bus.req_ready;
  assign err  = (bus.req_size == 2'd3) | ((bus.req_size == 2'd1) & off[0]) |
                ((bus.req_size == 2'd2) & (|off)) | (bus.req_addr < BASE_ADDR) | ({1'b0, offs} >= WIN);
  assign bus.ram_addr       = acc ? offs[ADDR_WIDTH+1:2] : addr_q;
  assign bus.ram_wr_en      = acc & bus.req_we & ~err;
  assign bus.ram_wr_data    = bus.req_size == 2'd0 ? {4{bus.req_wdata[7:0]}} :
                              bus.req_size == 2'd1 ? {2{bus.req_wdata[15:0]}} : bus.req_wdata;
  assign bus.ram_wr_byte_en = ~acc ? 4'b0000 : bus.req_size == 2'd0 ? 4'b0001 << off :
                              bus.req_size == 2'd1 ? 4'b0011 << off : 4'b1111;
  assign sh        = bus.ram_rd_data >> {p_off, 3'b000};
  assign ext       = ~p_uns & (p_size == 2'd0 ? sh[7] : sh[15]);
  assign fmt_rdata = (p_we | p_err) ? 32'h0 : p_size == 2'd0 ? {{24{ext}}, sh[7:0]} :
                     p_size == 2'd1 ? {{16{ext}}, sh[15:0]} : sh;
  // credit counts the in-flight P1 slot so the FIFO can never overflow
  assign pop           = bus.rsp_ready & (count != 2'd0);
  assign bus.rsp_valid = count != 2'd0;
  assign bus.req_ready = ({1'b0, count} + {2'b00, p_valid}) < 3'd3;
  assign bus.rsp_rdata = bus.rsp_valid ? fifo_rdata[rptr] : 32'h0;
  assign bus.rsp_err   = bus.rsp_valid & fifo_err[rptr];
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      addr_q  <= '0;
      p_valid <= 1'b0;
      p_we    <= 1'b0;
      p_uns   <= 1'b0;
      p_err   <= 1'b0;
      p_size  <= 2'd0;
      p_off   <= 2'd0;
      wptr    <= 2'd0;
      rptr    <= 2'd0;
      count   <= 2'd0;
    end else begin
      p_valid <= acc;
      if (acc) begin
        addr_q <= offs[ADDR_WIDTH+1:2];
        p_we   <= bus.req_we;
        p_uns  <= bus.req_unsigned;
        p_err  <= err;
        p_size <= bus.req_size;
        p_off  <= off;
      end
      if (p_valid) wptr <= wptr == 2'd2 ? 2'd0 : wptr + 2'd1;
      if (pop) rptr <= rptr == 2'd2 ? 2'd0 : rptr + 2'd1;
      count <= count + {1'b0, p_valid} - {1'b0, pop};
    end
  always_ff @(posedge clk)
    if (p_valid) begin
      fifo_rdata[wptr] <= fmt_rdata;
      fifo_err[wptr]   <= p_err;
    end
endmodule
